// File: rtl/mult_rr_scheduler.sv
// Round-robin arbiter sharing one 8x8 shift-add multiplier; result held until the owner acks.
// Optional MULT_RR_SCHEDULER_EARLY_TERM_EN: leave MUL as soon as the remaining multiplier bits are zero.
module mult_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int IDXW = 2
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [NREQ-1:0]   i_req,
  input  logic [NREQ*8-1:0] i_a_in,
  input  logic [NREQ*8-1:0] i_b_in,
  input  logic [NREQ-1:0]   i_ack,
  output logic [NREQ-1:0]   o_gnt,
  output logic [NREQ-1:0]   o_done,
  output logic [15:0]       o_prod,
  output logic [IDXW-1:0]   o_owner,
  output logic              o_busy,
  output logic              o_eop
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [NREQ-1:0]   r_gnt;
  logic [NREQ-1:0]   r_done;
  logic [15:0]       r_prod;
  logic [15:0]       r_acc;
  logic [15:0]       r_mcand;
  logic [7:0]        r_mplier;
  logic [2:0]        r_cnt;
  logic [IDXW-1:0]   r_owner;
  logic [IDXW-1:0]   r_last;

  logic              w_any;
  logic [IDXW:0]     w_idx;
  logic [IDXW-1:0]   w_winner;
  logic [15:0]       w_acc_sum;
  logic              w_mul_last;

  // Scan from farthest to nearest so the requester closest after r_last is assigned last and wins.
  always_comb begin
    w_any    = |i_req;
    w_winner = '0;
    w_idx    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = {1'b0, r_last} + (IDXW+1)'(k);
      if (w_idx >= (IDXW+1)'(NREQ)) begin
        w_idx = w_idx - (IDXW+1)'(NREQ);
      end
      if (i_req[w_idx[IDXW-1:0]]) begin
        w_winner = w_idx[IDXW-1:0];
      end
    end
  end

  always_comb begin
    w_acc_sum = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
`ifdef MULT_RR_SCHEDULER_EARLY_TERM_EN
    w_mul_last = (r_cnt == 3'd7) || (r_mplier[7:1] == 7'd0);
`else
    w_mul_last = (r_cnt == 3'd7);
`endif
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any)           w_next = S_MUL;
      S_MUL:   if (w_mul_last)      w_next = S_DONE;
      S_DONE:  if (i_ack[r_owner])  w_next = S_IDLE;
      default:                      w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (r_state != S_IDLE);
    o_eop  = |r_done;
  end

  // Datapath: operands are captured only on the grant edge.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_gnt    <= '0;
      r_done   <= '0;
      r_prod   <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_owner  <= '0;
      r_last   <= IDXW'(NREQ-1);
    end else begin
      r_gnt <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt[w_winner] <= 1'b1;
            r_owner         <= w_winner;
            r_last          <= w_winner;
            r_mplier        <= i_a_in[8*w_winner +: 8];
            r_mcand         <= {8'b0, i_b_in[8*w_winner +: 8]};
            r_acc           <= '0;
            r_prod          <= '0;
            r_cnt           <= '0;
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_sum;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 3'd1;
          if (w_mul_last) begin
            r_prod          <= w_acc_sum;
            r_done[r_owner] <= 1'b1;
          end
        end
        S_DONE: begin
          if (i_ack[r_owner]) begin
            r_done <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_gnt   = r_gnt;
  assign o_done  = r_done;
  assign o_prod  = r_prod;
  assign o_owner = r_owner;

endmodule
